// File: rtl/mips32_mem_pkg.sv
// Shared types and defaults for the mips32 unified-memory arbiter.
package mips32_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
endpackage

// File: rtl/mips32_arb2.sv
// Combinational two-requester picker: fetch port vs load/store port.
module mips32_arb2
  import mips32_mem_pkg::*;
#(
  parameter int DPORT_PRIO = 1
) (
  input  logic if_req,
  input  logic d_req,
  input  logic last_owner,
  output logic valid,
  output logic owner
);

  always_comb begin
    valid = if_req | d_req;
    owner = OWN_D;
    // on a tie round-robin hands the slot to the port that did not go last
    if (if_req && d_req) owner = (DPORT_PRIO != 0) ? OWN_D : ~last_owner;
    else if (if_req)     owner = OWN_IF;
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory controller sharing one 1024x32 memory between fetch and load/store.
// state  | meaning
// IDLE   | sample requests, pulse rvalid of the access that just finished
// ACCESS | drive the memory strobe and the winner's grant for one cycle
// WAIT   | count down the fixed memory latency, capture read data at count 1
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int DPORT_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t     state;
  logic [2:0] cnt;
  logic       last_owner;
  logic       owner;
  logic       lat_we;
  logic       pick_valid;
  logic       pick_owner;

  mips32_arb2 #(.DPORT_PRIO(DPORT_PRIO)) u_arb (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OWN_D;
      owner      <= OWN_IF;
      lat_we     <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt && pick_valid) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            owner      <= pick_owner;
            last_owner <= pick_owner;
            mem_en     <= 1'b1;
            if (pick_owner == OWN_D) begin
              d_gnt     <= 1'b1;
              lat_we    <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              if_gnt   <= 1'b1;
              lat_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        ACCESS: begin
          cnt   <= 3'(MEM_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            // stores complete with an rvalid but leave d_rdata untouched
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              if (!lat_we) d_rdata <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench: two arbiter instances (data priority and round-robin) with behavioural memories.
module tb_mips32_mem_arbiter;
  localparam int LAT = 2;
  localparam int P   = LAT + 2;
  localparam int NR  = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [9:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        p_if_gnt, p_if_rvalid, p_d_gnt, p_d_rvalid, p_mem_en, p_mem_we, p_busy;
  logic [31:0] p_if_rdata, p_d_rdata, p_mem_wdata, p_mem_rdata;
  logic [9:0]  p_mem_addr;
  logic        r_if_gnt, r_if_rvalid, r_d_gnt, r_d_rvalid, r_mem_en, r_mem_we, r_busy;
  logic [31:0] r_if_rdata, r_d_rdata, r_mem_wdata, r_mem_rdata;
  logic [9:0]  r_mem_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] salt = 32'h0;
  logic [31:0] ref_mem [0:1023];

  logic [31:0] mem_p [0:1023];
  logic [31:0] mem_r [0:1023];
  logic [9:0]  pa_p = '0, pa_r = '0;
  logic [2:0]  pc_p = 3'd0, pc_r = 3'd0;
  logic        ld_all = 1'b0, ld_one = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  bit          e_ig [0:NR+15];
  bit          e_dg [0:NR+15];
  bit          e_ir [0:NR+15];
  bit          e_dr [0:NR+15];
  bit          e_dld [0:NR+15];
  bit          e_busy [0:NR+15];
  bit          e_mwe [0:NR+15];
  logic [9:0]  e_ma [0:NR+15];
  logic [31:0] e_iv [0:NR+15];
  logic [31:0] e_dv [0:NR+15];

  always #5 clk = ~clk;

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT), .DPORT_PRIO(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid), .if_rdata(p_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .busy(p_busy)
  );

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT), .DPORT_PRIO(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(r_if_gnt), .if_rvalid(r_if_rvalid), .if_rdata(r_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(r_d_gnt), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
    .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_rdata(r_mem_rdata), .busy(r_busy)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ salt;
  endfunction

  // Fixed-latency memories: read data is only valid in the cycle LAT after mem_en.
  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 1024; i++) begin
        mem_p[i] <= init_word(i);
        mem_r[i] <= init_word(i);
      end
    end else if (ld_one) begin
      mem_p[ld_addr] <= ld_data;
      mem_r[ld_addr] <= ld_data;
    end else begin
      if (p_mem_en && p_mem_we) mem_p[p_mem_addr] <= p_mem_wdata;
      if (r_mem_en && r_mem_we) mem_r[r_mem_addr] <= r_mem_wdata;
    end
    if (p_mem_en) begin pa_p <= p_mem_addr; pc_p <= 3'(LAT); end
    else if (pc_p != 3'd0) pc_p <= pc_p - 3'd1;
    if (r_mem_en) begin pa_r <= r_mem_addr; pc_r <= 3'(LAT); end
    else if (pc_r != 3'd0) pc_r <= pc_r - 3'd1;
  end

  assign p_mem_rdata = (pc_p == 3'd1) ? mem_p[pa_p] : 32'hBAD0_0BAD;
  assign r_mem_rdata = (pc_r == 3'd1) ? mem_r[pa_r] : 32'hBAD0_0BAD;

  // Returns at a falling edge with reset released; the DUTs are idle in that cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    ld_all = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    ld_all = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    ld_addr = a; ld_data = v; ld_one = 1'b1;
    @(negedge clk);
    ld_one = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({p_if_gnt, p_d_gnt, p_if_rvalid, p_d_rvalid, p_mem_en, p_mem_we, p_busy, p_mem_addr, p_mem_wdata, p_if_rdata, p_d_rdata} !== '0) begin
      errors++; $display("FAIL reset_p got %h exp 0", {p_if_gnt, p_d_gnt, p_if_rvalid, p_d_rvalid, p_mem_en, p_mem_we, p_busy, p_mem_addr, p_mem_wdata, p_if_rdata, p_d_rdata}); end
    checks++; if ({r_if_gnt, r_d_gnt, r_if_rvalid, r_d_rvalid, r_mem_en, r_mem_we, r_busy, r_mem_addr, r_mem_wdata, r_if_rdata, r_d_rdata} !== '0) begin
      errors++; $display("FAIL reset_r got %h exp 0", {r_if_gnt, r_d_gnt, r_if_rvalid, r_d_rvalid, r_mem_en, r_mem_we, r_busy, r_mem_addr, r_mem_wdata, r_if_rdata, r_d_rdata}); end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    preload(10'h010, 32'h2000_0005);
    if_req = 1'b1; if_addr = 10'h010;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      checks++; if (p_if_gnt !== (k == 1)) begin errors++; $display("FAIL fetch_gnt k=%0d got %0b", k, p_if_gnt); end
      checks++; if (p_mem_en !== (k == 1)) begin errors++; $display("FAIL fetch_mem_en k=%0d got %0b", k, p_mem_en); end
      checks++; if (p_busy !== (k <= LAT + 1)) begin errors++; $display("FAIL fetch_busy k=%0d got %0b", k, p_busy); end
      checks++; if (p_if_rvalid !== (k == LAT + 2)) begin errors++; $display("FAIL fetch_rvalid k=%0d got %0b", k, p_if_rvalid); end
      if (k == 1) begin
        checks++; if (p_mem_addr !== 10'h010 || p_mem_we !== 1'b0) begin
          errors++; $display("FAIL fetch_mem_addr got %h we %0b exp 010 we 0", p_mem_addr, p_mem_we); end
        if_req = 1'b0;
      end
      if (k == LAT + 2) begin
        checks++; if (p_if_rdata !== 32'h2000_0005) begin errors++; $display("FAIL fetch_rdata got %h exp 20000005", p_if_rdata); end
      end
    end
  endtask

  task automatic test_tie_prio();
    logic [9:0] ia;
    do_reset();
    ia = 10'($urandom_range(1022));
    if_req = 1'b1; if_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
    for (int k = 1; k <= 2 * P + 1; k++) begin
      @(negedge clk);
      checks++; if (p_d_gnt !== (k == 1)) begin errors++; $display("FAIL tie_d_gnt k=%0d got %0b", k, p_d_gnt); end
      checks++; if (p_if_gnt !== (k == P + 1)) begin errors++; $display("FAIL tie_if_gnt k=%0d got %0b", k, p_if_gnt); end
      checks++; if (p_d_rvalid !== (k == P)) begin errors++; $display("FAIL tie_d_rvalid k=%0d got %0b", k, p_d_rvalid); end
      checks++; if (p_if_rvalid !== (k == 2 * P)) begin errors++; $display("FAIL tie_if_rvalid k=%0d got %0b", k, p_if_rvalid); end
      if (k == P) begin
        checks++; if (p_d_rdata !== ref_mem[10'h3FF]) begin errors++; $display("FAIL tie_d_rdata got %h exp %h", p_d_rdata, ref_mem[10'h3FF]); end
      end
      if (k == 2 * P) begin
        checks++; if (p_if_rdata !== ref_mem[ia]) begin errors++; $display("FAIL tie_if_rdata got %h exp %h", p_if_rdata, ref_mem[ia]); end
      end
      if (p_d_gnt) d_req = 1'b0;
      if (p_if_gnt) if_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [9:0] ia, da;
    int n;
    bit exp_ig, exp_dg, exp_ir, exp_dr;
    do_reset();
    ia = 10'($urandom); da = 10'($urandom);
    if_req = 1'b1; if_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
    for (int k = 1; k <= 4 * P; k++) begin
      @(negedge clk);
      n = (k - 1) / P;
      exp_ig = (k % P == 1) && (n % 2 == 0);
      exp_dg = (k % P == 1) && (n % 2 == 1);
      exp_ir = (k % P == 0) && ((k / P - 1) % 2 == 0);
      exp_dr = (k % P == 0) && ((k / P - 1) % 2 == 1);
      checks++; if (r_if_gnt !== exp_ig) begin errors++; $display("FAIL rr_if_gnt k=%0d got %0b exp %0b", k, r_if_gnt, exp_ig); end
      checks++; if (r_d_gnt !== exp_dg) begin errors++; $display("FAIL rr_d_gnt k=%0d got %0b exp %0b", k, r_d_gnt, exp_dg); end
      checks++; if (r_if_rvalid !== exp_ir) begin errors++; $display("FAIL rr_if_rvalid k=%0d got %0b exp %0b", k, r_if_rvalid, exp_ir); end
      checks++; if (r_d_rvalid !== exp_dr) begin errors++; $display("FAIL rr_d_rvalid k=%0d got %0b exp %0b", k, r_d_rvalid, exp_dr); end
      if (exp_ir) begin
        checks++; if (r_if_rdata !== ref_mem[ia]) begin errors++; $display("FAIL rr_if_rdata got %h exp %h", r_if_rdata, ref_mem[ia]); end
      end
      if (exp_dr) begin
        checks++; if (r_d_rdata !== ref_mem[da]) begin errors++; $display("FAIL rr_d_rdata got %h exp %h", r_d_rdata, ref_mem[da]); end
      end
      if (k == 1 + 3 * P) begin if_req = 1'b0; d_req = 1'b0; end
    end
  endtask

  task automatic test_store_load();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      checks++; if (p_mem_we !== (k == 1)) begin errors++; $display("FAIL st_mem_we k=%0d got %0b", k, p_mem_we); end
      checks++; if (p_d_rvalid !== (k == P)) begin errors++; $display("FAIL st_rvalid k=%0d got %0b", k, p_d_rvalid); end
      if (k == 1) begin
        checks++; if (p_mem_en !== 1'b1 || p_mem_addr !== 10'h020 || p_mem_wdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL st_mem got en %0b addr %h data %h exp 1 020 deadbeef", p_mem_en, p_mem_addr, p_mem_wdata); end
        d_req = 1'b0;
      end
    end
    checks++; if (p_d_rdata !== 32'h0) begin errors++; $display("FAIL st_rdata_hold got %h exp 0", p_d_rdata); end
    ref_mem[10'h020] = 32'hDEAD_BEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020; d_wdata = 32'h0;
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      checks++; if (p_d_gnt !== (k == 1)) begin errors++; $display("FAIL ld_gnt k=%0d got %0b", k, p_d_gnt); end
      checks++; if (p_d_rvalid !== (k == P)) begin errors++; $display("FAIL ld_rvalid k=%0d got %0b", k, p_d_rvalid); end
      if (k == 1) d_req = 1'b0;
    end
    checks++; if (p_d_rdata !== ref_mem[10'h020]) begin errors++; $display("FAIL ld_rdata got %h exp %h", p_d_rdata, ref_mem[10'h020]); end
  endtask

  task automatic test_halt();
    logic [9:0] ia, da;
    int h;
    bit exp_busy;
    h = LAT + 6;
    do_reset();
    ia = 10'($urandom); da = 10'($urandom);
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    for (int k = 1; k <= h + LAT + 2; k++) begin
      @(negedge clk);
      exp_busy = (k <= LAT + 1) || (k >= h + 1 && k <= h + LAT + 1);
      checks++; if (p_d_gnt !== (k == 1)) begin errors++; $display("FAIL halt_d_gnt k=%0d got %0b", k, p_d_gnt); end
      checks++; if (p_if_gnt !== (k == h + 1)) begin errors++; $display("FAIL halt_if_gnt k=%0d got %0b", k, p_if_gnt); end
      checks++; if (p_d_rvalid !== (k == LAT + 2)) begin errors++; $display("FAIL halt_d_rvalid k=%0d got %0b", k, p_d_rvalid); end
      checks++; if (p_if_rvalid !== (k == h + LAT + 2)) begin errors++; $display("FAIL halt_if_rvalid k=%0d got %0b", k, p_if_rvalid); end
      checks++; if (p_busy !== exp_busy) begin errors++; $display("FAIL halt_busy k=%0d got %0b exp %0b", k, p_busy, exp_busy); end
      if (k == LAT + 2) begin
        checks++; if (p_d_rdata !== ref_mem[da]) begin errors++; $display("FAIL halt_d_rdata got %h exp %h", p_d_rdata, ref_mem[da]); end
      end
      if (k == h + LAT + 2) begin
        checks++; if (p_if_rdata !== ref_mem[ia]) begin errors++; $display("FAIL halt_if_rdata got %h exp %h", p_if_rdata, ref_mem[ia]); end
      end
      if (k == 1) d_req = 1'b0;
      if (k == 2) begin halt = 1'b1; if_req = 1'b1; if_addr = ia; end
      if (k == h) halt = 1'b0;
      if (k == h + 1) if_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'($urandom);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({p_d_gnt, p_d_rvalid, p_mem_en, p_mem_we, p_busy, p_mem_addr, p_mem_wdata, p_d_rdata, p_if_rdata} !== '0) begin
      errors++; $display("FAIL rstmid_p got %h exp 0", {p_d_gnt, p_d_rvalid, p_mem_en, p_mem_we, p_busy, p_mem_addr, p_mem_wdata, p_d_rdata, p_if_rdata}); end
    checks++; if ({r_d_gnt, r_d_rvalid, r_mem_en, r_mem_we, r_busy, r_mem_addr, r_mem_wdata, r_d_rdata, r_if_rdata} !== '0) begin
      errors++; $display("FAIL rstmid_r got %h exp 0", {r_d_gnt, r_d_rvalid, r_mem_en, r_mem_we, r_busy, r_mem_addr, r_mem_wdata, r_d_rdata, r_if_rdata}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (p_d_rvalid !== 1'b0 || r_d_rvalid !== 1'b0) begin
        errors++; $display("FAIL rstmid_rvalid k=%0d got p %0b r %0b exp 0", k, p_d_rvalid, r_d_rvalid); end
      checks++; if (p_busy !== 1'b0 || r_busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_busy k=%0d got p %0b r %0b exp 0", k, p_busy, r_busy); end
    end
    if_req = 1'b1; if_addr = 10'($urandom); d_req = 1'b1; d_addr = 10'($urandom);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    checks++; if (r_if_gnt !== 1'b1 || r_d_gnt !== 1'b0) begin
      errors++; $display("FAIL rstmid_rr_tie got if %0b d %0b exp if 1 d 0", r_if_gnt, r_d_gnt); end
    checks++; if (p_d_gnt !== 1'b1 || p_if_gnt !== 1'b0) begin
      errors++; $display("FAIL rstmid_prio_tie got if %0b d %0b exp if 0 d 1", p_if_gnt, p_d_gnt); end
  endtask

  // Random traffic on the data-priority instance against a transaction-schedule model:
  // a request sampled free in cycle t is granted at t+1 and answered at t+LAT+2.
  task automatic test_random();
    bit pi, pd, dwe, hl;
    logic [9:0]  ia, da;
    logic [31:0] dw, exp_ir, exp_dr;
    int free_at, g, r;
    do_reset();
    for (int i = 0; i < NR + 16; i++) begin
      e_ig[i] = 0; e_dg[i] = 0; e_ir[i] = 0; e_dr[i] = 0; e_dld[i] = 0;
      e_busy[i] = 0; e_mwe[i] = 0; e_ma[i] = '0; e_iv[i] = '0; e_dv[i] = '0;
    end
    pi = 0; pd = 0; dwe = 0; ia = '0; da = '0; dw = '0;
    exp_ir = '0; exp_dr = '0; free_at = 0;
    for (int t = 0; t < NR; t++) begin
      if (t > 0) @(negedge clk);
      if (e_ir[t]) exp_ir = e_iv[t];
      if (e_dld[t]) exp_dr = e_dv[t];
      checks++; if (p_if_gnt !== e_ig[t]) begin errors++; $display("FAIL rnd_if_gnt t=%0d got %0b exp %0b", t, p_if_gnt, e_ig[t]); end
      checks++; if (p_d_gnt !== e_dg[t]) begin errors++; $display("FAIL rnd_d_gnt t=%0d got %0b exp %0b", t, p_d_gnt, e_dg[t]); end
      checks++; if (p_if_rvalid !== e_ir[t]) begin errors++; $display("FAIL rnd_if_rvalid t=%0d got %0b exp %0b", t, p_if_rvalid, e_ir[t]); end
      checks++; if (p_d_rvalid !== e_dr[t]) begin errors++; $display("FAIL rnd_d_rvalid t=%0d got %0b exp %0b", t, p_d_rvalid, e_dr[t]); end
      checks++; if (p_busy !== e_busy[t]) begin errors++; $display("FAIL rnd_busy t=%0d got %0b exp %0b", t, p_busy, e_busy[t]); end
      checks++; if (p_if_rdata !== exp_ir) begin errors++; $display("FAIL rnd_if_rdata t=%0d got %h exp %h", t, p_if_rdata, exp_ir); end
      checks++; if (p_d_rdata !== exp_dr) begin errors++; $display("FAIL rnd_d_rdata t=%0d got %h exp %h", t, p_d_rdata, exp_dr); end
      checks++; if (p_mem_en !== (e_ig[t] | e_dg[t])) begin errors++; $display("FAIL rnd_mem_en t=%0d got %0b", t, p_mem_en); end
      if (e_ig[t] | e_dg[t]) begin
        checks++; if (p_mem_addr !== e_ma[t] || p_mem_we !== e_mwe[t]) begin
          errors++; $display("FAIL rnd_mem t=%0d got addr %h we %0b exp %h %0b", t, p_mem_addr, p_mem_we, e_ma[t], e_mwe[t]); end
      end
      if (e_ig[t]) pi = 0;
      if (e_dg[t]) pd = 0;
      if (!pi && $urandom_range(3) == 0) begin pi = 1; ia = 10'($urandom); end
      if (!pd && $urandom_range(2) == 0) begin
        pd = 1; dwe = 1'($urandom_range(1)); da = 10'($urandom_range(31)); dw = $urandom;
      end
      hl = ($urandom_range(7) == 0);
      if_req = pi; if_addr = ia; d_req = pd; d_we = dwe; d_addr = da; d_wdata = dw; halt = hl;
      if (t >= free_at && !hl && (pi || pd)) begin
        g = t + 1;
        r = t + LAT + 2;
        if (pd) begin
          e_dg[g] = 1; e_ma[g] = da; e_mwe[g] = dwe; e_dr[r] = 1;
          if (dwe) ref_mem[da] = dw;
          else begin e_dld[r] = 1; e_dv[r] = ref_mem[da]; end
        end else begin
          e_ig[g] = 1; e_ma[g] = ia; e_mwe[g] = 0; e_ir[r] = 1; e_iv[r] = ref_mem[ia];
        end
        for (int b = g; b < r; b++) e_busy[b] = 1;
        free_at = r;
      end
    end
    if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_fetch();
    test_tie_prio();
    test_round_robin();
    test_store_load();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
